// File: rtl/sb_config_ctrl.sv
// Configuration controller for NUM_SB switch-box elements: shadow store written by a host,
// atomically committed to the active configuration bus, with read-back and bulk clear.
module sb_config_ctrl #(
    parameter  int unsigned NUM_SB = 16,
    parameter  int unsigned ADDR_W = 4,
    localparam int unsigned DATA_W = 16,
    localparam int unsigned EPOCH_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [DATA_W*NUM_SB-1:0] cfg_out,
    output logic [EPOCH_W-1:0]       cfg_epoch,
    output logic                     busy,
    output logic                     err,
    input  logic                     err_clr
);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_COMMIT = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RESP
    } state_e;

    localparam logic [ADDR_W:0]   NUM_SB_X = (ADDR_W+1)'(NUM_SB);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SB - 1);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     shadow_q [NUM_SB];
    logic [DATA_W-1:0]     shadow_d [NUM_SB];
    logic [DATA_W-1:0]     active_q [NUM_SB];
    logic [DATA_W-1:0]     active_d [NUM_SB];
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [EPOCH_W-1:0]    epoch_q, epoch_d;
    logic                  err_q, err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic                  addr_ok_c;
    logic                  err_set_c;

    assign addr_ok_c = ({1'b0, cmd_addr} < NUM_SB_X);

    // State and store registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            epoch_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int i = 0; i < int'(NUM_SB); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            epoch_q     <= epoch_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    // Command decode, clear walk and response handshake
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        idx_d       = idx_q;
        epoch_d     = epoch_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        err_set_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            if (addr_ok_c) shadow_d[cmd_addr] = cmd_data;
                            else           err_set_c = 1'b1;
                        end
                        OP_READ: begin
                            rsp_valid_d = 1'b1;
                            state_d     = ST_RESP;
                            if (addr_ok_c) begin
                                rsp_data_d = shadow_q[cmd_addr];
                            end else begin
                                rsp_data_d = '0;
                                err_set_c  = 1'b1;
                            end
                        end
                        OP_COMMIT: begin
                            active_d = shadow_q;
                            epoch_d  = epoch_q + EPOCH_W'(1);
                        end
                        OP_CLEAR: begin
                            idx_d   = '0;
                            state_d = ST_CLEAR;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                shadow_d[idx_q] = '0;
                idx_d           = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new error outranks a simultaneous clear
        if (err_clr)   err_d = 1'b0;
        if (err_set_c) err_d = 1'b1;
    end

    for (genvar g = 0; g < int'(NUM_SB); g++) begin : g_cfg
        assign cfg_out[DATA_W*g +: DATA_W] = active_q[g];
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cfg_epoch = epoch_q;
    assign err       = err_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sb_config_ctrl.sv
// Self-checking bench for sb_config_ctrl: a 16-element instance for the main flows and a
// 12-element instance for out-of-range addressing; read responses checked via a scoreboard.
module tb_sb_config_ctrl;

    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_CM = 2'b10;
    localparam logic [1:0] OP_CL = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [3:0]   cmd_addr = '0;
    logic [15:0]  cmd_data = '0;
    logic         rsp_valid, rsp_ready = 1'b0;
    logic [15:0]  rsp_data;
    logic [255:0] cfg_out;
    logic [7:0]   cfg_epoch;
    logic         busy, err, err_clr = 1'b0;

    logic         e_cmd_valid = 1'b0, e_cmd_ready;
    logic [1:0]   e_cmd_op = '0;
    logic [3:0]   e_cmd_addr = '0;
    logic [15:0]  e_cmd_data = '0;
    logic         e_rsp_valid, e_rsp_ready = 1'b0;
    logic [15:0]  e_rsp_data;
    logic [191:0] e_cfg_out;
    logic [7:0]   e_cfg_epoch;
    logic         e_busy, e_err, e_err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] shadow_m [16];
    logic [15:0] active_m [16];
    logic [7:0]  exp_epoch;
    logic [15:0] exp_q [$];
    logic [15:0] e_shadow_m [12];
    logic [15:0] e_active_m [12];
    logic [15:0] e_exp_q [$];

    sb_config_ctrl #(.NUM_SB(16), .ADDR_W(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cfg_out(cfg_out), .cfg_epoch(cfg_epoch), .busy(busy), .err(err), .err_clr(err_clr)
    );

    sb_config_ctrl #(.NUM_SB(12), .ADDR_W(4)) u_dut12 (
        .clk(clk), .rst(rst), .cmd_valid(e_cmd_valid), .cmd_ready(e_cmd_ready),
        .cmd_op(e_cmd_op), .cmd_addr(e_cmd_addr), .cmd_data(e_cmd_data),
        .rsp_valid(e_rsp_valid), .rsp_ready(e_rsp_ready), .rsp_data(e_rsp_data),
        .cfg_out(e_cfg_out), .cfg_epoch(e_cfg_epoch), .busy(e_busy), .err(e_err),
        .err_clr(e_err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] flat16();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = active_m[i];
        return r;
    endfunction

    function automatic logic [191:0] flat12();
        logic [191:0] r;
        for (int i = 0; i < 12; i++) r[16*i +: 16] = e_active_m[i];
        return r;
    endfunction

    task automatic reset_models();
        for (int i = 0; i < 16; i++) begin shadow_m[i] = '0; active_m[i] = '0; end
        for (int i = 0; i < 12; i++) begin e_shadow_m[i] = '0; e_active_m[i] = '0; end
        exp_epoch = '0;
        exp_q.delete();
        e_exp_q.delete();
    endtask

    // One accepted command on the 16-element instance; the model and scoreboard follow it
    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        case (op)
            OP_WR: shadow_m[addr] = data;
            OP_RD: exp_q.push_back(shadow_m[addr]);
            OP_CM: begin active_m = shadow_m; exp_epoch = exp_epoch + 8'd1; end
            default: for (int i = 0; i < 16; i++) shadow_m[i] = '0;
        endcase
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic e_drive_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data);
        e_cmd_valid = 1'b1; e_cmd_op = op; e_cmd_addr = addr; e_cmd_data = data;
        case (op)
            OP_WR: if (addr < 4'd12) e_shadow_m[addr] = data;
            OP_RD: e_exp_q.push_back((addr < 4'd12) ? e_shadow_m[addr] : 16'h0000);
            OP_CM: e_active_m = e_shadow_m;
            default: for (int i = 0; i < 12; i++) e_shadow_m[i] = '0;
        endcase
        step();
        e_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        reset_models();
        checks++;
        if (cfg_out !== '0) begin errors++; $display("FAIL reset_cfg_out got %h want 0", cfg_out); end
        checks++;
        if (cfg_epoch !== 8'd0) begin errors++; $display("FAIL reset_epoch got %0d want 0", cfg_epoch); end
        checks++;
        if ({err, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL reset_flags err/rsp_valid/busy/cmd_ready got %b want 0001",
                               {err, rsp_valid, busy, cmd_ready});
        end
        checks++;
        if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    endtask

    task automatic test_commit();
        logic [255:0] exp;
        drive_cmd(OP_WR, 4'd3, 16'h1B6C);
        drive_cmd(OP_WR, 4'd0, 16'h0001);
        checks++;
        if (cfg_out !== '0) begin errors++; $display("FAIL commit_pre got %h want 0", cfg_out); end
        drive_cmd(OP_CM, 4'd0, 16'h0000);
        exp = '0;
        exp[63:48] = 16'h1B6C;
        exp[15:0]  = 16'h0001;
        checks++;
        if (cfg_out !== exp) begin errors++; $display("FAIL commit_cfg got %h want %h", cfg_out, exp); end
        checks++;
        if (cfg_epoch !== 8'd1) begin errors++; $display("FAIL commit_epoch got %0d want 1", cfg_epoch); end
    endtask

    task automatic test_read_backpressure();
        logic [15:0] exp;
        drive_cmd(OP_WR, 4'd5, 16'hA5A5);
        drive_cmd(OP_RD, 4'd5, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({rsp_valid, cmd_ready, busy} !== 3'b101 || rsp_data !== 16'hA5A5) begin
                errors++;
                $display("FAIL rd_hold cyc %0d valid/ready/busy got %b want 101 data got %h want a5a5",
                         c, {rsp_valid, cmd_ready, busy}, rsp_data);
            end
            if (c < 3) step();
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_data !== exp) begin errors++; $display("FAIL rd_data got %h want %h", rsp_data, exp); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL rd_after_hs valid/ready got %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_clear();
        logic [15:0] exp;
        logic [3:0]  addrs [3];
        int cnt;
        int wait_cnt;
        addrs[0] = 4'd7; addrs[1] = 4'd0; addrs[2] = 4'd15;
        for (int i = 0; i < 16; i++) drive_cmd(OP_WR, 4'(i), 16'hFFFF);
        drive_cmd(OP_CM, 4'd0, 16'h0000);
        checks++;
        if (cfg_out !== {256{1'b1}}) begin errors++; $display("FAIL clear_fill got %h want all ones", cfg_out); end
        drive_cmd(OP_CL, 4'd9, 16'h1234);
        cnt = 0;
        while (busy && cnt < 64) begin
            if (cfg_out !== {256{1'b1}} || cmd_ready !== 1'b0) begin
                checks++; errors++;
                $display("FAIL clear_during cyc %0d cfg %h ready %b want all ones and 0", cnt, cfg_out, cmd_ready);
            end
            step();
            cnt++;
        end
        checks++;
        if (cnt != 16) begin errors++; $display("FAIL clear_busy_cycles got %0d want 16", cnt); end
        for (int k = 0; k < 3; k++) begin
            drive_cmd(OP_RD, addrs[k], 16'h0000);
            wait_cnt = 0;
            while (!rsp_valid && wait_cnt < 20) begin step(); wait_cnt++; end
            checks++;
            if (!rsp_valid) begin
                errors++; $display("FAIL clear_rd_timeout addr %0d got no response want rsp_valid", addrs[k]);
                void'(exp_q.pop_front());
            end else begin
                exp = exp_q.pop_front();
                if (rsp_data !== exp || exp !== 16'h0000) begin
                    errors++; $display("FAIL clear_rd addr %0d got %h want 0000", addrs[k], rsp_data);
                end
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        drive_cmd(OP_CM, 4'd0, 16'h0000);
        checks++;
        if (cfg_out !== '0) begin errors++; $display("FAIL clear_commit got %h want 0", cfg_out); end
        checks++;
        if (cfg_epoch !== exp_epoch) begin errors++; $display("FAIL clear_epoch got %0d want %0d", cfg_epoch, exp_epoch); end
    endtask

    task automatic test_errors();
        logic [15:0] exp;
        int wait_cnt;
        e_drive_cmd(OP_WR, 4'd3, 16'h1234);
        e_drive_cmd(OP_WR, 4'd13, 16'hFFFF);
        checks++;
        if (e_err !== 1'b1) begin errors++; $display("FAIL err_wr13 got %b want 1", e_err); end
        e_drive_cmd(OP_CM, 4'd0, 16'h0000);
        checks++;
        if (e_cfg_out !== flat12()) begin errors++; $display("FAIL err_no_store got %h want %h", e_cfg_out, flat12()); end
        e_err_clr = 1'b1; step(); e_err_clr = 1'b0;
        checks++;
        if (e_err !== 1'b0) begin errors++; $display("FAIL err_clr1 got %b want 0", e_err); end
        for (int k = 0; k < 2; k++) begin
            e_drive_cmd(OP_RD, (k == 0) ? 4'd12 : 4'd3, 16'h0000);
            wait_cnt = 0;
            while (!e_rsp_valid && wait_cnt < 20) begin step(); wait_cnt++; end
            checks++;
            if (!e_rsp_valid) begin
                errors++; $display("FAIL err_rd_timeout k %0d got no response want rsp_valid", k);
                void'(e_exp_q.pop_front());
            end else begin
                exp = e_exp_q.pop_front();
                if (e_rsp_data !== exp) begin errors++; $display("FAIL err_rd k %0d got %h want %h", k, e_rsp_data, exp); end
            end
            checks++;
            if (e_err !== 1'b1) begin errors++; $display("FAIL err_rd_flag k %0d got %b want 1", k, e_err); end
            e_rsp_ready = 1'b1; step(); e_rsp_ready = 1'b0;
        end
        e_err_clr = 1'b1; step(); e_err_clr = 1'b0;
        e_err_clr = 1'b1;
        e_drive_cmd(OP_WR, 4'd14, 16'h5555);
        e_err_clr = 1'b0;
        checks++;
        if (e_err !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", e_err); end
        checks++;
        if (e_cmd_ready !== 1'b1) begin errors++; $display("FAIL err_not_blocking ready got %b want 1", e_cmd_ready); end
        e_err_clr = 1'b1; step(); e_err_clr = 1'b0;
        checks++;
        if (e_err !== 1'b0) begin errors++; $display("FAIL err_clr2 got %b want 0", e_err); end
    endtask

    task automatic test_reset_mid_clear();
        logic [15:0] exp;
        int wait_cnt;
        for (int i = 0; i < 16; i++) drive_cmd(OP_WR, 4'(i), 16'(16'h0101 * (i + 1)));
        drive_cmd(OP_CM, 4'd0, 16'h0000);
        drive_cmd(OP_CL, 4'd0, 16'h0000);
        for (int c = 0; c < 7; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_models();
        checks++;
        if (cfg_out !== '0 || cfg_epoch !== 8'd0) begin
            errors++; $display("FAIL midclr_rst cfg %h epoch %0d want 0 and 0", cfg_out, cfg_epoch);
        end
        checks++;
        if ({busy, cmd_ready, err, rsp_valid} !== 4'b0100) begin
            errors++; $display("FAIL midclr_state busy/ready/err/valid got %b want 0100",
                               {busy, cmd_ready, err, rsp_valid});
        end
        drive_cmd(OP_RD, 4'd15, 16'h0000);
        wait_cnt = 0;
        while (!rsp_valid && wait_cnt < 20) begin step(); wait_cnt++; end
        checks++;
        if (!rsp_valid) begin
            errors++; $display("FAIL midclr_rd_timeout got no response want rsp_valid");
            void'(exp_q.pop_front());
        end else begin
            exp = exp_q.pop_front();
            if (rsp_data !== exp) begin errors++; $display("FAIL midclr_rd15 got %h want %h", rsp_data, exp); end
        end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    endtask

    task automatic test_epoch_wrap();
        for (int i = 0; i < 255; i++) drive_cmd(OP_CM, 4'd0, 16'h0000);
        checks++;
        if (cfg_epoch !== 8'hFF || exp_epoch !== 8'hFF) begin
            errors++; $display("FAIL epoch_255 got %0d want 255", cfg_epoch);
        end
        drive_cmd(OP_CM, 4'd0, 16'h0000);
        checks++;
        if (cfg_epoch !== 8'h00) begin errors++; $display("FAIL epoch_wrap got %0d want 0", cfg_epoch); end
        checks++;
        if (cfg_out !== flat16()) begin errors++; $display("FAIL epoch_cfg got %h want %h", cfg_out, flat16()); end
    endtask

    initial begin
        reset_models();
        test_reset();
        test_commit();
        test_read_backpressure();
        test_clear();
        test_errors();
        test_reset_mid_clear();
        test_epoch_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
